memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
Sits directly downstream of the instruction cache and the data/vector load-store unit. It arbitrates both onto a single main-memory port.
- Instruction port: single-word reads using the existing mem_vis_signal / mem_status handshake.
- Data port: word bursts of 1..MAX_BURST words, read or write.
- Data has priority over instructions. mem_status is broadcast to both requesters so either can stall.

Parameters:
ADDR_WIDTH, 17, byte address width (word-aligned accesses only)
LEN, 32, word width
MAX_BURST, 8, max words per data burst
BURST_W, 4, width of burst length field (holds 0..MAX_BURST)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_vis_signal  in  2  MEM_NOP / MEM_READ from instruction cache
inst_vis_addr  in  ADDR_WIDTH  instruction word address
inst_data  out  LEN  fetched word; valid while mem_status==MEM_INST_WORKING
data_vis_signal  in  2  MEM_NOP / MEM_READ / MEM_WRITE
data_vis_addr  in  ADDR_WIDTH  burst base address
data_vis_len  in  BURST_W  burst length in words
data_wdata  in  MAX_BURST*LEN  store data, word i at bits [i*LEN +: LEN]
data_rdata  out  MAX_BURST*LEN  load data, valid when data_done==1
data_done  out  1  one-cycle pulse at burst completion
mem_status  out  2  MEM_RESTING / MEM_INST_WORKING / MEM_DATA_WORKING
ram_addr  out  ADDR_WIDTH  main memory address
ram_we  out  1  main memory write enable
ram_wdata  out  LEN  main memory write data
ram_rdata  in  LEN  main memory read data (combinational read of ram_addr)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, mem_status=MEM_RESTING, data_done=0, ram_we=0.
  - ram_addr=0, ram_wdata=0, inst_data=0, data_rdata=0, word counter=0.
  - Reset mid-burst aborts the burst. No write occurs after rst_n falls. No data_done is produced.
- States:
  - IDLE: mem_status=MEM_RESTING.
  - INST: 1 cycle, mem_status=MEM_INST_WORKING.
  - DATA: mem_status=MEM_DATA_WORKING.
  - DONE: 1 cycle, mem_status=MEM_DATA_WORKING, data_done=1.
- Requests are sampled only at an edge where state==IDLE. Requests seen in any other state are ignored, not queued; requesters re-issue after seeing MEM_RESTING.
- Arbitration in IDLE, evaluated in this order:
  1. data_vis_signal!=NOP with data_vis_len!=0 → DATA. Data wins over a simultaneous inst READ.
  2. Otherwise inst_vis_signal==MEM_READ → INST.
  3. data_vis_len==0 → treated as NOP.
  4. data_vis_len>MAX_BURST → clamped to MAX_BURST.
- Instruction read timing:
  - Cycle N: IDLE, inst READ accepted; ram_addr<=inst_vis_addr registered at end of N.
  - Cycle N+1: mem_status=MEM_INST_WORKING; inst_data equals ram_rdata combinationally.
  - Edge ending N+1: state → IDLE.
  - Result: one word per 2 cycles, back-to-back.
- Data burst:
  - On acceptance, latch base address, length L, signal, and data_wdata. Counter k=0.
  - Each DATA cycle: ram_addr=base+4k.
  - Write: ram_we=1, ram_wdata=word k.
  - Read: ram_rdata captured into data_rdata word k at the edge.
  - k increments per cycle. After word L-1 → DONE → IDLE.
  - Burst of L words takes L DATA cycles plus 1 DONE cycle. MEM_DATA_WORKING is held throughout.
  - Unread words of data_rdata keep their previous values.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Low 2 address bits are forced to 0.
- ram_we is 0 in every state except DATA-with-write.
- Input changes during DATA have no effect, because all burst inputs are latched.

Decomposition:
- Shared defines (already in defines.v): MEM_NOP, MEM_READ, MEM_WRITE, MEM_RESTING, MEM_INST_WORKING, MEM_DATA_WORKING, TRUE, FALSE.
- New defines: controller state encodings MC_IDLE, MC_INST, MC_DATA, MC_DONE.
- One natural sub-module: mem_burst_sequencer (counter, address generation, word select/capture), instantiated by memory_controller, which owns arbitration and the status output.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs → mem_status=RESTING, ram_we=0, data_done=0. Assert rst_n=0 mid-burst → ram_we drops the same cycle, with no data_done.
- Instruction read: ram[0x100]=0xDEADBEEF; inst READ addr 0x100 → next cycle mem_status=INST_WORKING and inst_data=0xDEADBEEF; following cycle RESTING.
- Collision: inst READ 0x0 and data READ 0x40 with len=2 in the same cycle → DATA_WORKING for 3 cycles; data_rdata words 0,1 = ram[0x40],ram[0x44]; no INST_WORKING until the inst request is re-issued.
- Write burst: WRITE addr 0x80, len=8, data words 1..8 → ram_we=1 for exactly 8 cycles at 0x80..0x9C; ram holds 1..8; data_done pulses once.
- Boundaries: len=0 → stays RESTING. len=15 → clamped to 8 words. Base 0x1FFFC, len=2 → second word at address 0x00000.
- Ignore-while-busy: inst READ held throughout a 4-word data burst → exactly one INST_WORKING cycle, occurring after DONE.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared encodings, sizes and helpers for the main-memory arbiter.
// Imported by memory_controller and mem_burst_sequencer.
package memory_controller_pkg;

  localparam int ADDR_WIDTH = 17;
  localparam int LEN        = 32;
  localparam int MAX_BURST  = 8;
  localparam int BURST_W    = 4;

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] MEM_RESTING      = 2'b00;
  localparam logic [1:0] MEM_INST_WORKING = 2'b01;
  localparam logic [1:0] MEM_DATA_WORKING = 2'b10;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_INST = 2'd1,
    MC_DATA = 2'd2,
    MC_DONE = 2'd3
  } mc_state_t;

  function automatic logic [BURST_W-1:0] clamp_len(
    input logic [BURST_W-1:0] len
  );
    if (len > BURST_W'(MAX_BURST))
      return BURST_W'(MAX_BURST);
    return len;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] word_align(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a & ~ADDR_WIDTH'(3);
  endfunction

endpackage

// File: rtl/mem_burst_sequencer.sv
// Burst counter, address generator, store-word select and load capture.
// Ports: start/inst_load/active control, burst params, RAM side, rdata.
module mem_burst_sequencer
  import memory_controller_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       write,
  input  logic [ADDR_WIDTH-1:0]      base,
  input  logic [BURST_W-1:0]         len,
  input  logic [MAX_BURST*LEN-1:0]   wdata,
  input  logic                       inst_load,
  input  logic [ADDR_WIDTH-1:0]      inst_addr,
  input  logic                       active,
  output logic                       last,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic                       ram_we,
  output logic [LEN-1:0]             ram_wdata,
  input  logic [LEN-1:0]             ram_rdata,
  output logic [MAX_BURST*LEN-1:0]   rdata
);

  localparam int IW = $clog2(MAX_BURST);

  logic [ADDR_WIDTH-1:0]    base_q;
  logic [BURST_W-1:0]       len_q;
  logic                     wr_q;
  logic [MAX_BURST*LEN-1:0] wbuf;
  logic [IW-1:0]            cnt;
  logic [IW-1:0]            nxt;
  logic [ADDR_WIDTH-1:0]    noff;

  assign nxt  = cnt + 1'b1;
  assign noff = {{(ADDR_WIDTH-IW-2){1'b0}}, nxt, 2'b00};
  assign last = (BURST_W'(cnt) == len_q - 1'b1);

  // ram_addr/ram_we/ram_wdata are registered one word ahead so the
  // RAM sees word k during the k-th DATA cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      wr_q      <= 1'b0;
      wbuf      <= '0;
      cnt       <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      rdata     <= '0;
    end else if (start) begin
      base_q    <= word_align(base);
      len_q     <= len;
      wr_q      <= write;
      wbuf      <= wdata;
      cnt       <= '0;
      ram_addr  <= word_align(base);
      ram_we    <= write;
      ram_wdata <= wdata[LEN-1:0];
    end else if (inst_load) begin
      ram_addr  <= word_align(inst_addr);
      ram_we    <= 1'b0;
    end else if (active) begin
      if (!wr_q)
        rdata[cnt*LEN +: LEN] <= ram_rdata;
      if (last) begin
        ram_we    <= 1'b0;
      end else begin
        cnt       <= nxt;
        ram_addr  <= base_q + noff;
        ram_wdata <= wbuf[nxt*LEN +: LEN];
      end
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Arbitrates icache word reads and LSU bursts onto one memory port.
// Ports: inst_*, data_*, mem_status broadcast, ram_* memory side.
module memory_controller
  import memory_controller_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               inst_vis_signal,
  input  logic [ADDR_WIDTH-1:0]    inst_vis_addr,
  output logic [LEN-1:0]           inst_data,
  input  logic [1:0]               data_vis_signal,
  input  logic [ADDR_WIDTH-1:0]    data_vis_addr,
  input  logic [BURST_W-1:0]       data_vis_len,
  input  logic [MAX_BURST*LEN-1:0] data_wdata,
  output logic [MAX_BURST*LEN-1:0] data_rdata,
  output logic                     data_done,
  output logic [1:0]               mem_status,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  output logic                     ram_we,
  output logic [LEN-1:0]           ram_wdata,
  input  logic [LEN-1:0]           ram_rdata
);

  mc_state_t state;
  logic      data_req;
  logic      inst_req;
  logic      start;
  logic      inst_load;
  logic      last;

  // A zero-length burst is a NOP, so it never blocks the icache.
  assign data_req  = (data_vis_signal != MEM_NOP) &&
                     (data_vis_len != '0);
  assign inst_req  = (inst_vis_signal == MEM_READ);
  assign start     = (state == MC_IDLE) && data_req;
  assign inst_load = (state == MC_IDLE) && !data_req && inst_req;

  assign inst_data = (state == MC_INST) ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= MC_IDLE;
      mem_status <= MEM_RESTING;
      data_done  <= 1'b0;
    end else begin
      data_done <= 1'b0;
      unique case (state)
        MC_IDLE: begin
          unique case (1'b1)
            start: begin
              state      <= MC_DATA;
              mem_status <= MEM_DATA_WORKING;
            end
            inst_load: begin
              state      <= MC_INST;
              mem_status <= MEM_INST_WORKING;
            end
            default: ;
          endcase
        end
        MC_INST: begin
          state      <= MC_IDLE;
          mem_status <= MEM_RESTING;
        end
        MC_DATA: begin
          if (last) begin
            state     <= MC_DONE;
            data_done <= 1'b1;
          end
        end
        MC_DONE: begin
          state      <= MC_IDLE;
          mem_status <= MEM_RESTING;
        end
        default: begin
          state      <= MC_IDLE;
          mem_status <= MEM_RESTING;
        end
      endcase
    end
  end

  mem_burst_sequencer u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .write     (data_vis_signal == MEM_WRITE),
    .base      (data_vis_addr),
    .len       (clamp_len(data_vis_len)),
    .wdata     (data_wdata),
    .inst_load (inst_load),
    .inst_addr (inst_vis_addr),
    .active    (state == MC_DATA),
    .last      (last),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .rdata     (data_rdata)
  );

endmodule

// File: tb/tb_memory_controller.sv
// Directed + random bench for memory_controller with a word-array RAM
// and an arithmetic model of burst lengths, addresses and data.
module tb_memory_controller;
  import memory_controller_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   inst_vis_signal;
  logic [16:0]  inst_vis_addr;
  logic [31:0]  inst_data;
  logic [1:0]   data_vis_signal;
  logic [16:0]  data_vis_addr;
  logic [3:0]   data_vis_len;
  logic [255:0] data_wdata;
  logic [255:0] data_rdata;
  logic         data_done;
  logic [1:0]   mem_status;
  logic [16:0]  ram_addr;
  logic         ram_we;
  logic [31:0]  ram_wdata;
  logic [31:0]  ram_rdata;

  logic [31:0] mem     [32768];
  logic [31:0] exp_mem [32768];
  logic [31:0] exp_rd  [8];

  int errors = 0;
  int checks = 0;

  memory_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_vis_signal (inst_vis_signal),
    .inst_vis_addr   (inst_vis_addr),
    .inst_data       (inst_data),
    .data_vis_signal (data_vis_signal),
    .data_vis_addr   (data_vis_addr),
    .data_vis_len    (data_vis_len),
    .data_wdata      (data_wdata),
    .data_rdata      (data_rdata),
    .data_done       (data_done),
    .mem_status      (mem_status),
    .ram_addr        (ram_addr),
    .ram_we          (ram_we),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr >> 2];

  always @(posedge clk)
    if (ram_we) mem[ram_addr >> 2] <= ram_wdata;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input int len);
    if (len == 0) return 0;
    if (len > 8) return 8;
    return len;
  endfunction

  function automatic logic [16:0] waddr(input logic [16:0] base,
                                        input int i);
    logic [16:0] b;
    b = base & ~17'd3;
    return b + 17'(4 * i);
  endfunction

  function automatic logic [255:0] rand_words();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic idle_inputs();
    inst_vis_signal = MEM_NOP;
    inst_vis_addr   = '0;
    data_vis_signal = MEM_NOP;
    data_vis_addr   = '0;
    data_vis_len    = '0;
    data_wdata      = '0;
  endtask

  task automatic inst_read(input logic [16:0] a);
    inst_vis_signal = MEM_READ;
    inst_vis_addr   = a;
    step();
    inst_vis_signal = MEM_NOP;
    chk("inst_status", mem_status, MEM_INST_WORKING);
    chk("inst_data", inst_data, exp_mem[a >> 2]);
    chk("inst_we", ram_we, 0);
    step();
    chk("inst_rest", mem_status, MEM_RESTING);
  endtask

  task automatic run_burst(input logic [1:0]   sig,
                           input logic [16:0]  base,
                           input int           len,
                           input logic [255:0] wd,
                           input bit           with_inst,
                           input bit           hold_inst,
                           input logic [16:0]  iaddr);
    int  lc, k, data_cyc, we_cyc, done_cyc, inst_cyc, early;
    bit  done_seen;
    bit  wr;
    lc = eff_len(len);
    wr = (sig == MEM_WRITE);
    k = 0; data_cyc = 0; we_cyc = 0; done_cyc = 0;
    inst_cyc = 0; early = 0; done_seen = 0;
    for (int i = 0; i < lc; i++) begin
      if (wr) exp_mem[waddr(base, i) >> 2] = wd[i*32 +: 32];
      else    exp_rd[i] = exp_mem[waddr(base, i) >> 2];
    end
    data_vis_signal = sig;
    data_vis_addr   = base;
    data_vis_len    = 4'(len);
    data_wdata      = wd;
    inst_vis_signal = with_inst ? MEM_READ : MEM_NOP;
    inst_vis_addr   = iaddr;
    step();
    data_vis_signal = MEM_NOP;
    data_vis_addr   = 17'($urandom);
    data_vis_len    = 4'($urandom);
    data_wdata      = rand_words();
    if (!hold_inst) inst_vis_signal = MEM_NOP;
    for (int c = 0; c < 14; c++) begin
      if (ram_we) we_cyc++;
      if (data_done) begin
        done_cyc++;
        done_seen = 1;
      end
      if (mem_status == MEM_DATA_WORKING) begin
        data_cyc++;
        if (!data_done && k < 8) begin
          chk("burst_addr", ram_addr, waddr(base, k));
          chk("burst_we", ram_we, wr);
          if (wr) chk("burst_wdata", ram_wdata, wd[k*32 +: 32]);
          k++;
        end
      end
      if (mem_status == MEM_INST_WORKING) begin
        inst_cyc++;
        if (lc != 0 && !done_seen) early++;
        chk("burst_inst_data", inst_data, exp_mem[iaddr >> 2]);
        inst_vis_signal = MEM_NOP;
      end
      step();
    end
    chk("burst_data_cycles", data_cyc, lc == 0 ? 0 : lc + 1);
    chk("burst_done_pulses", done_cyc, lc == 0 ? 0 : 1);
    chk("burst_we_cycles", we_cyc, wr ? lc : 0);
    chk("burst_inst_cycles", inst_cyc,
        (with_inst && (hold_inst || lc == 0)) ? 1 : 0);
    chk("burst_inst_early", early, 0);
    chk("burst_end_status", mem_status, MEM_RESTING);
    for (int i = 0; i < 8; i++)
      chk("burst_rdata", data_rdata[i*32 +: 32], exp_rd[i]);
    if (wr)
      for (int i = 0; i < lc; i++)
        chk("burst_mem", mem[waddr(base, i) >> 2],
            exp_mem[waddr(base, i) >> 2]);
  endtask

  initial begin
    logic [255:0] wd;
    logic [16:0]  a;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = $urandom;
      exp_mem[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) exp_rd[i] = '0;
    idle_inputs();

    // reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      inst_vis_signal = 2'($urandom_range(0, 1));
      inst_vis_addr   = 17'($urandom);
      data_vis_signal = 2'($urandom_range(0, 2));
      data_vis_addr   = 17'($urandom);
      data_vis_len    = 4'($urandom);
      data_wdata      = rand_words();
      step();
      chk("rst_status", mem_status, MEM_RESTING);
      chk("rst_we", ram_we, 0);
      chk("rst_done", data_done, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_rdata", data_rdata[63:0], 0);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_status", mem_status, MEM_RESTING);

    // single instruction reads, back to back
    mem[17'h100 >> 2]     = 32'hDEADBEEF;
    exp_mem[17'h100 >> 2] = 32'hDEADBEEF;
    inst_read(17'h100);
    inst_read(17'h1F0);
    inst_read(17'h004);

    // collision: data wins, dropped inst request is not queued
    run_burst(MEM_READ, 17'h40, 2, rand_words(), 1, 0, 17'h0);
    inst_read(17'h0);

    // full write burst of 1..8
    for (int i = 0; i < 8; i++) wd[i*32 +: 32] = 32'(i + 1);
    run_burst(MEM_WRITE, 17'h80, 8, wd, 0, 0, 17'h0);
    run_burst(MEM_READ, 17'h80, 8, rand_words(), 0, 0, 17'h0);

    // zero length, clamping, address wrap
    run_burst(MEM_READ, 17'h300, 0, rand_words(), 0, 0, 17'h0);
    run_burst(MEM_WRITE, 17'h400, 15, rand_words(), 0, 0, 17'h0);
    run_burst(MEM_WRITE, 17'h1FFFC, 2, rand_words(), 0, 0, 17'h0);
    run_burst(MEM_READ, 17'h1FFFC, 2, rand_words(), 0, 0, 17'h0);

    // inst held for a whole burst gets served once, after it
    run_burst(MEM_READ, 17'h500, 4, rand_words(), 1, 1, 17'h100);

    // reset in the middle of a write burst
    wd = rand_words();
    data_vis_signal = MEM_WRITE;
    data_vis_addr   = 17'h200;
    data_vis_len    = 4'd8;
    data_wdata      = wd;
    step();
    idle_inputs();
    step();
    step();
    chk("midrst_we_before", ram_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", ram_we, 0);
    chk("midrst_status", mem_status, MEM_RESTING);
    chk("midrst_done", data_done, 0);
    step();
    step();
    chk("midrst_done_hold", data_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++)
      exp_mem[(17'h200 >> 2) + i] = wd[i*32 +: 32];
    for (int i = 0; i < 8; i++) begin
      exp_rd[i] = '0;
      chk("midrst_mem", mem[(17'h200 >> 2) + i],
          exp_mem[(17'h200 >> 2) + i]);
    end
    step();
    chk("midrst_idle", mem_status, MEM_RESTING);
    chk("midrst_rdata", data_rdata[31:0], 0);
    inst_read(17'h200);

    // random traffic
    for (int n = 0; n < 30; n++) begin
      a = 17'($urandom) & ~17'd3;
      if ($urandom_range(0, 3) == 0) begin
        inst_read(a);
      end else begin
        run_burst($urandom_range(0, 1) ? MEM_WRITE : MEM_READ,
                  17'($urandom), $urandom_range(0, 15),
                  rand_words(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), a);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
